beat_packer: RTL and testbench

Input-side assembly stage for the array-port datapath. Collects a stream of narrow beats through a valid/ready handshake and assembles them into one 72-bit word of type `word_t` (`logic [0:2][3:2][0:3][0:2]`), the array element shape carried by the downstream 4-state array ports. Early termination is supported: a short word is zero-padded and flagged. X/Z content is tracked per word and counted, so downstream 4-state resolution issues are visible at the source.

---
 rtl/packer_pkg.sv | 13 +
 rtl/beat_xz_check.sv | 11 +
 rtl/beat_packer.sv | 123 ++++++++++++
 tb/tb_beat_packer.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/packer_pkg.sv
// Shared types for the beat packer: assembled word shape and FSM states.
package packer_pkg;

  localparam int WORD_W = 72;

  typedef logic [0:2][3:2][0:3][0:2] word_t;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } pk_state_e;

endpackage

// File: rtl/beat_xz_check.sv
// Flags a beat carrying any X or Z bit using a 4-state reduction.
module beat_xz_check #(
  parameter int BEAT_W = 8
) (
  input  logic [BEAT_W-1:0] beat,
  output logic              has_xz
);

  assign has_xz = ((^beat) === 1'bx);

endmodule

// File: rtl/beat_packer.sv
// Assembles narrow beats MSB-first into one word_t, with early termination
// (zero-padded, flagged short) and per-word X/Z tracking.
//
// state | meaning
// FILL  | collecting beats into the accumulator, in_ready=1
// HOLD  | assembled word presented, in_ready follows out_ready
module beat_packer
  import packer_pkg::*;
#(
  parameter int BEAT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BEAT_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output word_t             out_data,
  output logic              out_short,
  output logic              out_xz,
  output logic [15:0]       xz_count
);

  localparam int BEATS = WORD_W / BEAT_W;
  localparam int IDX_W = $clog2(BEATS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

  if (WORD_W % BEAT_W != 0) begin : g_bad_beat_w
    $error("beat_packer: WORD_W must be a multiple of BEAT_W");
  end

  pk_state_e         state_q, state_d;
  logic [IDX_W-1:0]  idx;
  logic [WORD_W-1:0] acc;
  logic [WORD_W-1:0] acc_ins;
  logic              xz_flag;
  logic              beat_xz;
  logic              xz_next;
  logic              in_fire;
  logic              out_fire;
  logic              is_last_idx;
  logic              complete;
  word_t             out_data_q;
  logic              out_short_q;
  logic              out_xz_q;

  beat_xz_check #(.BEAT_W(BEAT_W)) u_xz_check (
    .beat   (in_data),
    .has_xz (beat_xz)
  );

  always_comb begin
    in_ready = 1'b0;
    state_d  = state_q;
    case (state_q)
      FILL: begin
        in_ready = rst_n;
        if (complete) state_d = HOLD;
      end
      HOLD: begin
        in_ready = rst_n & out_ready;
        if (out_fire && !complete) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  assign out_valid   = (state_q == HOLD);
  assign in_fire     = in_valid && in_ready;
  assign out_fire    = out_valid && out_ready;
  assign is_last_idx = (idx == LAST_IDX);
  assign complete    = in_fire && (is_last_idx || in_last);
  assign xz_next     = xz_flag | beat_xz;

  always_comb begin
    acc_ins = acc;
    for (int i = 0; i < BEATS; i++) begin
      if (idx == IDX_W'(i)) acc_ins[WORD_W-1-i*BEAT_W -: BEAT_W] = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FILL;
    else        state_q <= state_d;
  end

  // acc/idx/xz_flag are zeroed on completion, so a beat taken in HOLD
  // naturally lands as beat 0 of a fresh word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc         <= '0;
      idx         <= '0;
      xz_flag     <= 1'b0;
      out_data_q  <= '0;
      out_short_q <= 1'b0;
      out_xz_q    <= 1'b0;
      xz_count    <= '0;
    end else begin
      if (in_fire) begin
        if (complete) begin
          out_data_q  <= acc_ins;
          out_short_q <= in_last && !is_last_idx;
          out_xz_q    <= xz_next;
          acc         <= '0;
          idx         <= '0;
          xz_flag     <= 1'b0;
        end else begin
          acc     <= acc_ins;
          idx     <= idx + IDX_W'(1);
          xz_flag <= xz_next;
        end
      end
      if (out_fire && out_xz_q && (xz_count != 16'hFFFF)) xz_count <= xz_count + 16'd1;
    end
  end

  assign out_data  = out_data_q;
  assign out_short = out_short_q;
  assign out_xz    = out_xz_q;

endmodule

// File: tb/tb_beat_packer.sv
// Directed and randomized checks of beat_packer against a word-level model.
module tb_beat_packer;
  import packer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  word_t       out_data;
  logic        out_short;
  logic        out_xz;
  logic [15:0] xz_count;

  int total = 0;
  int bad = 0;
  int exp_xz_count = 0;

  typedef struct {
    logic [71:0] data;
    logic        short_w;
    logic        xz;
  } exp_t;

  exp_t exp_q[$];

  beat_packer #(.BEAT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_short (out_short),
    .out_xz    (out_xz),
    .xz_count  (xz_count)
  );

  always #5 clk = ~clk;

  // Word-level reference: beat k occupies byte (8-k) counting from the LSB.
  function automatic exp_t model_word(input logic [7:0] beats[$]);
    exp_t e;
    e.data = '0;
    e.xz = 1'b0;
    for (int k = 0; k < beats.size(); k++) begin
      e.data = e.data | ({64'd0, beats[k]} << (8 * (8 - k)));
      if ($isunknown(beats[k])) e.xz = 1'b1;
    end
    e.short_w = (beats.size() < 9);
    return e;
  endfunction

  task automatic drive_beat(input logic [7:0] d, input logic last);
    bit ok = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL handshake_timeout in_ready=%b required=1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h5A;
    in_last = 1'b1;
    out_ready = 1'b1;
    #3;
    total++;
    if ({out_valid, out_short, out_xz} !== 3'b000 || out_data !== '0 || xz_count !== 16'd0) begin
      bad++;
      $display("FAIL reset_outputs got v=%b s=%b x=%b d=%h c=%0d required all zero",
               out_valid, out_short, out_xz, out_data, xz_count);
    end
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_in_ready got=%b required=0", in_ready);
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if ({out_valid, out_short, out_xz} !== 3'b000 || out_data !== '0 || xz_count !== 16'd0
        || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL post_release got v=%b s=%b x=%b d=%h c=%0d rdy=%b required zeros rdy=1",
               out_valid, out_short, out_xz, out_data, xz_count, in_ready);
    end
    exp_xz_count = 0;
  endtask

  task automatic test_full_word();
    out_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      drive_beat(8'(k + 1), k == 8);
      if (k == 7) begin
        total++;
        if (out_valid !== 1'b0) begin
          bad++;
          $display("FAIL full_early_valid got=%b required=0", out_valid);
        end
      end
    end
    total++;
    if (out_valid !== 1'b1 || out_data !== 72'h010203040506070809 || out_short !== 1'b0
        || out_xz !== 1'b0) begin
      bad++;
      $display("FAIL full_word got v=%b d=%h s=%b x=%b required v=1 d=010203040506070809 s=0 x=0",
               out_valid, out_data, out_short, out_xz);
    end
    @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL full_drain got=%b required=0", out_valid);
    end
  endtask

  task automatic test_short_word();
    out_ready = 1'b1;
    drive_beat(8'hAA, 1'b0);
    drive_beat(8'hBB, 1'b0);
    drive_beat(8'hCC, 1'b1);
    total++;
    if (out_valid !== 1'b1 || out_data !== 72'hAABBCC000000000000 || out_short !== 1'b1) begin
      bad++;
      $display("FAIL short_word got v=%b d=%h s=%b required v=1 d=AABBCC000000000000 s=1",
               out_valid, out_data, out_short);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    bit stable_ok = 1;
    out_ready = 1'b0;
    for (int k = 0; k < 9; k++) drive_beat(8'h30 + 8'(k), k == 8);
    in_valid = 1'b1;
    in_data = 8'h5A;
    in_last = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_data !== 72'h303132333435363738 || in_ready !== 1'b0)
        stable_ok = 0;
      @(posedge clk);
      #1;
    end
    total++;
    if (!stable_ok) begin
      bad++;
      $display("FAIL stall_hold got v=%b d=%h rdy=%b required v=1 d=303132333435363738 rdy=0",
               out_valid, out_data, in_ready);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL stall_release got v=%b required=0", out_valid);
    end
    for (int k = 0; k < 8; k++) drive_beat(8'(k + 1), k == 7);
    total++;
    if (out_valid !== 1'b1 || out_data !== 72'h5A0102030405060708 || out_short !== 1'b0) begin
      bad++;
      $display("FAIL stall_next_word got v=%b d=%h s=%b required v=1 d=5A0102030405060708 s=0",
               out_valid, out_data, out_short);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    logic [7:0] b[$];
    exp_t e1, e2;
    int accepted = 0;
    bit vld_ok = 1;
    for (int i = 0; i < 18; i++) b.push_back(8'($urandom_range(0, 255)));
    e1 = model_word(b[0:8]);
    e2 = model_word(b[9:17]);
    out_ready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      in_valid = 1'b1;
      in_data = b[i];
      in_last = 1'b0;
      @(negedge clk);
      if (in_ready === 1'b1) accepted++;
      if (out_valid !== (i == 9)) vld_ok = 0;
      if (i == 9) begin
        total++;
        if (out_data !== e1.data || out_short !== 1'b0) begin
          bad++;
          $display("FAIL b2b_word1 got d=%h s=%b required d=%h s=0", out_data, out_short, e1.data);
        end
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    total++;
    if (accepted != 18) begin
      bad++;
      $display("FAIL b2b_accepted got=%0d required=18", accepted);
    end
    total++;
    if (!vld_ok) begin
      bad++;
      $display("FAIL b2b_valid_pattern got gap or extra out_valid required single pulse at beat 9");
    end
    total++;
    if (out_valid !== 1'b1 || out_data !== e2.data || out_short !== 1'b0) begin
      bad++;
      $display("FAIL b2b_word2 got v=%b d=%h required v=1 d=%h", out_valid, out_data, e2.data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_xz();
    logic [7:0] b[$];
    logic [7:0] xb;
    exp_t e;
    xb = 8'bxxxx0000;
    b = '{8'h01, 8'h02, xb, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
    e = model_word(b);
    out_ready = 1'b1;
    for (int k = 0; k < 9; k++) drive_beat(b[k], 1'b0);
    total++;
    if (out_valid !== 1'b1 || out_xz !== e.xz || out_data !== e.data) begin
      bad++;
      $display("FAIL xz_word got v=%b x=%b d=%h required v=1 x=%b d=%h",
               out_valid, out_xz, out_data, e.xz, e.data);
    end
    @(posedge clk);
    #1;
    if (e.xz) exp_xz_count++;
    total++;
    if (xz_count !== 16'(exp_xz_count)) begin
      bad++;
      $display("FAIL xz_count_inc got=%0d required=%0d", xz_count, exp_xz_count);
    end
    for (int k = 0; k < 9; k++) drive_beat(8'h40 + 8'(k), 1'b0);
    total++;
    if (out_xz !== 1'b0) begin
      bad++;
      $display("FAIL xz_clean_word got=%b required=0", out_xz);
    end
    @(posedge clk);
    #1;
    total++;
    if (xz_count !== 16'(exp_xz_count)) begin
      bad++;
      $display("FAIL xz_count_hold got=%0d required=%0d", xz_count, exp_xz_count);
    end
  endtask

  task automatic test_reset_mid_word();
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) drive_beat(8'hE0 + 8'(k), 1'b0);
    rst_n = 1'b0;
    #1;
    total++;
    if ({out_valid, out_short, out_xz, in_ready} !== 4'b0000 || out_data !== '0
        || xz_count !== 16'd0) begin
      bad++;
      $display("FAIL midreset_outputs got v=%b s=%b x=%b rdy=%b d=%h c=%0d required all zero",
               out_valid, out_short, out_xz, in_ready, out_data, xz_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_xz_count = 0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 9; k++) drive_beat(8'h11 * 8'(k + 1), k == 8);
    total++;
    if (out_valid !== 1'b1 || out_data !== 72'h112233445566778899 || out_short !== 1'b0) begin
      bad++;
      $display("FAIL midreset_word got v=%b d=%h s=%b required v=1 d=112233445566778899 s=0",
               out_valid, out_data, out_short);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    int got = 0;
    exp_q.delete();
    fork
      begin
        for (int w = 0; w < 20; w++) begin
          logic [7:0] b[$];
          logic [7:0] v;
          int n;
          n = $urandom_range(1, 9);
          for (int k = 0; k < n; k++) begin
            v = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) v = 8'bx0z01111;
            b.push_back(v);
          end
          exp_q.push_back(model_word(b));
          for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 2)) begin
              @(posedge clk);
              #1;
            end
            drive_beat(b[k], (k == n - 1) && (n < 9 || $urandom_range(0, 1) == 1));
          end
        end
      end
      begin
        for (int c = 0; c < 3000 && got < 20; c++) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 1) == 1);
          @(negedge clk);
          if (out_valid === 1'b1 && out_ready === 1'b1) begin
            exp_t e;
            total++;
            if (exp_q.size() == 0) begin
              bad++;
              $display("FAIL rand_unexpected_word got d=%h required no word", out_data);
            end else begin
              e = exp_q.pop_front();
              if (out_data !== e.data || out_short !== e.short_w || out_xz !== e.xz) begin
                bad++;
                $display("FAIL rand_word%0d got d=%h s=%b x=%b required d=%h s=%b x=%b",
                         got, out_data, out_short, out_xz, e.data, e.short_w, e.xz);
              end
              if (e.xz) exp_xz_count++;
            end
            got++;
          end
        end
        if (got < 20) begin
          total++;
          bad++;
          $display("FAIL rand_timeout got=%0d words required=20", got);
        end
      end
    join
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (xz_count !== 16'(exp_xz_count)) begin
      bad++;
      $display("FAIL rand_xz_count got=%0d required=%0d", xz_count, exp_xz_count);
    end
  endtask

  initial begin
    in_valid = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    out_ready = 1'b0;
    rst_n = 1'b0;
    test_reset();
    test_full_word();
    test_short_word();
    test_backpressure();
    test_back_to_back();
    test_xz();
    test_reset_mid_word();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
